// File: rtl/spi_periph_if.sv
// spi_periph_if: groups the transmit/receive handshake and the SPI pins of
// the SPI peripheral.
//   slave modport  - used by spi_periph (the peripheral itself)
//   master modport - used by whatever drives the peripheral and the SPI pins
// Signals:
//   tx_valid/tx_ready/tx_data            - word to send in the next frame
//   rx_valid/rx_data/rx_nbits            - received word, end-of-frame pulse
//   tx_underrun/rx_overrun               - one-cycle error pulses
//   SCLK/MOSI/SS_N (to peripheral), MISO - SPI link, mode 0
interface spi_periph_if #(
  parameter int SPI_MAXLEN = 8
);
  logic                          tx_valid;
  logic                          tx_ready;
  logic [SPI_MAXLEN-1:0]         tx_data;
  logic                          rx_valid;
  logic [SPI_MAXLEN-1:0]         rx_data;
  logic [$clog2(SPI_MAXLEN):0]   rx_nbits;
  logic                          tx_underrun;
  logic                          rx_overrun;
  logic                          SCLK;
  logic                          MOSI;
  logic                          SS_N;
  logic                          MISO;

  modport slave (
    input  tx_valid, tx_data, SCLK, MOSI, SS_N,
    output tx_ready, rx_valid, rx_data, rx_nbits, tx_underrun, rx_overrun, MISO
  );

  modport master (
    output tx_valid, tx_data, SCLK, MOSI, SS_N,
    input  tx_ready, rx_valid, rx_data, rx_nbits, tx_underrun, rx_overrun, MISO
  );
endinterface

// File: rtl/spi_periph.sv
// spi_periph: SPI mode 0 (CPOL=0, CPHA=0) peripheral, MSB first, frames of
// 1..SPI_MAXLEN bits delimited by SS_N. The SPI pins are oversampled in the
// clk domain; all edges are acted on SYNC_STAGES+1 clk after the pin edge.
// Ports:
//   clk    - system clock (period <= SCLK half-period / (SYNC_STAGES+2))
//   sreset - synchronous, active-high reset
//   bus    - spi_periph_if.slave: tx handshake, rx outputs, error pulses,
//            SCLK/MOSI/SS_N inputs and MISO output
module spi_periph #(
  parameter int SPI_MAXLEN  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         sreset,
  spi_periph_if.slave  bus
);

  localparam int CNT_W    = $clog2(SPI_MAXLEN) + 1;
  localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    ACTIVE,
    DONE
  } state_t;

  state_t state_reg, state_next;

  // Pin synchronizers and previous-value registers for edge detection.
  logic [SYNC_STAGES-1:0] sclk_sync_reg, mosi_sync_reg, ss_sync_reg;
  logic                   sclk_prev_reg, ss_prev_reg;
  logic                   sclk_sync, mosi_sync, ss_sync;
  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;

  // Datapath registers.
  logic [SPI_MAXLEN-1:0] tx_buf_reg, tx_buf_next;
  logic                  tx_full_reg, tx_full_next;
  logic [SPI_MAXLEN-1:0] tx_shift_reg, tx_shift_next;
  logic [SPI_MAXLEN-1:0] rx_shift_reg, rx_shift_next;
  logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic                  ovf_reg, ovf_next;
  logic                  miso_reg, miso_next;
  logic                  rx_valid_reg, rx_valid_next;
  logic [SPI_MAXLEN-1:0] rx_data_reg, rx_data_next;
  logic [CNT_W-1:0]      rx_nbits_reg, rx_nbits_next;
  logic                  tx_underrun_reg, tx_underrun_next;
  logic                  rx_overrun_reg, rx_overrun_next;
  logic [SETTLE_W-1:0]   settle_reg, settle_next;
  logic                  tx_accept;

  always_ff @(posedge clk) begin
    if (sreset) begin
      sclk_sync_reg <= '0;
      mosi_sync_reg <= '0;
      ss_sync_reg   <= '1;
      sclk_prev_reg <= 1'b0;
      ss_prev_reg   <= 1'b1;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], bus.SCLK};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], bus.MOSI};
      ss_sync_reg   <= {ss_sync_reg[SYNC_STAGES-2:0], bus.SS_N};
      sclk_prev_reg <= sclk_sync;
      ss_prev_reg   <= ss_sync;
    end
  end

  assign sclk_sync = sclk_sync_reg[SYNC_STAGES-1];
  assign mosi_sync = mosi_sync_reg[SYNC_STAGES-1];
  assign ss_sync   = ss_sync_reg[SYNC_STAGES-1];
  assign sclk_rise = sclk_sync & ~sclk_prev_reg;
  assign sclk_fall = ~sclk_sync & sclk_prev_reg;
  assign ss_rise   = ss_sync & ~ss_prev_reg;
  assign ss_fall   = ~ss_sync & ss_prev_reg;

  assign tx_accept = bus.tx_valid & ~tx_full_reg;

  always_ff @(posedge clk) begin
    if (sreset) begin
      state_reg <= WAIT_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    tx_buf_next      = tx_buf_reg;
    tx_full_next     = tx_full_reg;
    tx_shift_next    = tx_shift_reg;
    rx_shift_next    = rx_shift_reg;
    bit_cnt_next     = bit_cnt_reg;
    ovf_next         = ovf_reg;
    miso_next        = miso_reg;
    rx_valid_next    = 1'b0;
    rx_data_next     = rx_data_reg;
    rx_nbits_next    = rx_nbits_reg;
    tx_underrun_next = 1'b0;
    rx_overrun_next  = 1'b0;
    settle_next      = settle_reg;

    // Accept can only fire while the buffer is empty, so it never collides
    // with the buffer being consumed at the start of a frame.
    if (tx_accept) begin
      tx_buf_next  = bus.tx_data;
      tx_full_next = 1'b1;
    end

    case (state_reg)
      WAIT_IDLE: begin
        miso_next = 1'b0;
        // The synchronizer is preset high during reset, so a single high
        // sample proves nothing. Require the whole chain to stay high long
        // enough that every stage holds a real pin sample; a frame that was
        // in progress at reset release is then skipped.
        if (&ss_sync_reg) begin
          if (settle_reg == SETTLE_W'(SYNC_STAGES)) begin
            state_next  = IDLE;
            settle_next = '0;
          end else begin
            settle_next = settle_reg + SETTLE_W'(1);
          end
        end else begin
          settle_next = '0;
        end
      end

      IDLE: begin
        miso_next = 1'b0;
        if (ss_fall) begin
          state_next    = ACTIVE;
          rx_shift_next = '0;
          bit_cnt_next  = '0;
          ovf_next      = 1'b0;
          if (tx_full_reg) begin
            tx_shift_next = tx_buf_reg;
            tx_full_next  = 1'b0;
            miso_next     = tx_buf_reg[SPI_MAXLEN-1];
          end else begin
            tx_shift_next    = '0;
            tx_underrun_next = 1'b1;
            miso_next        = 1'b0;
          end
        end
      end

      ACTIVE: begin
        if (ss_rise) begin
          // SCLK edges seen in the same cycle as the deselect are dropped.
          state_next = DONE;
          miso_next  = 1'b0;
        end else if (sclk_rise) begin
          if (bit_cnt_reg < CNT_W'(SPI_MAXLEN)) begin
            rx_shift_next = (rx_shift_reg << 1) | SPI_MAXLEN'(mosi_sync);
            bit_cnt_next  = bit_cnt_reg + CNT_W'(1);
          end else begin
            ovf_next = 1'b1;
          end
        end else if (sclk_fall) begin
          tx_shift_next = tx_shift_reg << 1;
          miso_next     = tx_shift_next[SPI_MAXLEN-1];
        end
      end

      DONE: begin
        miso_next  = 1'b0;
        state_next = IDLE;
        if (bit_cnt_reg != '0) begin
          rx_valid_next   = 1'b1;
          rx_data_next    = rx_shift_reg;
          rx_nbits_next   = bit_cnt_reg;
          rx_overrun_next = ovf_reg;
        end
      end

      default: begin
        state_next = WAIT_IDLE;
        miso_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      tx_buf_reg      <= '0;
      tx_full_reg     <= 1'b0;
      tx_shift_reg    <= '0;
      rx_shift_reg    <= '0;
      bit_cnt_reg     <= '0;
      ovf_reg         <= 1'b0;
      miso_reg        <= 1'b0;
      rx_valid_reg    <= 1'b0;
      rx_data_reg     <= '0;
      rx_nbits_reg    <= '0;
      tx_underrun_reg <= 1'b0;
      rx_overrun_reg  <= 1'b0;
      settle_reg      <= '0;
    end else begin
      tx_buf_reg      <= tx_buf_next;
      tx_full_reg     <= tx_full_next;
      tx_shift_reg    <= tx_shift_next;
      rx_shift_reg    <= rx_shift_next;
      bit_cnt_reg     <= bit_cnt_next;
      ovf_reg         <= ovf_next;
      miso_reg        <= miso_next;
      rx_valid_reg    <= rx_valid_next;
      rx_data_reg     <= rx_data_next;
      rx_nbits_reg    <= rx_nbits_next;
      tx_underrun_reg <= tx_underrun_next;
      rx_overrun_reg  <= rx_overrun_next;
      settle_reg      <= settle_next;
    end
  end

  assign bus.tx_ready    = ~tx_full_reg;
  assign bus.rx_valid    = rx_valid_reg;
  assign bus.rx_data     = rx_data_reg;
  assign bus.rx_nbits    = rx_nbits_reg;
  assign bus.tx_underrun = tx_underrun_reg;
  assign bus.rx_overrun  = rx_overrun_reg;
  assign bus.MISO        = miso_reg;

endmodule

// File: tb/tb_spi_periph.sv
// tb_spi_periph: drives SPI mode 0 frames into spi_periph and compares MISO
// bits, received words and error pulses with a frame-level reference model.
module tb_spi_periph;

  localparam int MAXLEN = 8;
  localparam int SYNC   = 2;
  localparam int H      = 8;   // SCLK half-period in clk cycles

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] n;
    logic       o;
  } rx_t;

  logic clk;
  logic sreset;

  spi_periph_if #(.SPI_MAXLEN(MAXLEN)) bus ();

  spi_periph #(.SPI_MAXLEN(MAXLEN), .SYNC_STAGES(SYNC)) dut (
    .clk    (clk),
    .sreset (sreset),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  // Monitor: records every rx_valid pulse and error pulse.
  rx_t got_q[$];
  rx_t exp_q[$];
  int  und_cnt   = 0;
  int  exp_und   = 0;
  int  ovr_alone = 0;

  always @(negedge clk) begin
    if (bus.rx_valid) got_q.push_back({bus.rx_data, bus.rx_nbits, bus.rx_overrun});
    if (bus.tx_underrun) und_cnt++;
    if (bus.rx_overrun && !bus.rx_valid) ovr_alone++;
  end

  // Reference model of the tx buffer.
  logic       model_full;
  logic [7:0] model_word;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic load_tx(input logic [7:0] d);
    check("tx_ready", {31'd0, bus.tx_ready}, {31'd0, !model_full});
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    @(posedge clk); #1;
    bus.tx_valid = 1'b0;
    if (!model_full) begin
      model_full = 1'b1;
      model_word = d;
    end
  endtask

  // One frame of n bits; bits[n-1] goes out first. rst_at >= 0 pulses
  // sreset before that bit; fall_load offers fall_word in the SS_N-fall cycle.
  task automatic run_frame(input int n, input logic [15:0] bits, input int gap,
                           input int rst_at, input logic fall_load,
                           input logic [7:0] fall_word);
    logic       had;
    logic [7:0] w;
    logic       rst_hit;
    logic       exp_bit;
    int         keep;
    had     = model_full;
    w       = model_word;
    rst_hit = 1'b0;
    model_full = 1'b0;
    if (!had) exp_und++;
    @(posedge clk); #1;
    bus.SS_N = 1'b0;
    bus.MOSI = (n > 0) ? bits[n-1] : 1'b0;
    if (fall_load) begin
      repeat (SYNC) @(posedge clk);
      #1;
      bus.tx_valid = 1'b1;
      bus.tx_data  = fall_word;
      @(posedge clk); #1;
      bus.tx_valid = 1'b0;
      if (!had) begin
        model_full = 1'b1;
        model_word = fall_word;
      end
      repeat (H - SYNC - 1) @(posedge clk);
    end else begin
      repeat (H) @(posedge clk);
    end
    #1;
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        sreset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sreset = 1'b0;
        rst_hit = 1'b1;
        model_full = 1'b0;
        check("tx_ready_after_reset", {31'd0, bus.tx_ready}, 32'd1);
      end
      exp_bit = (!had || rst_hit || i >= MAXLEN) ? 1'b0 : w[MAXLEN-1-i];
      check("miso_bit", {31'd0, bus.MISO}, {31'd0, exp_bit});
      bus.SCLK = 1'b1;
      repeat (H) @(posedge clk);
      #1;
      bus.SCLK = 1'b0;
      bus.MOSI = (i + 1 < n) ? bits[n-2-i] : 1'b0;
      repeat (H) @(posedge clk);
      #1;
    end
    bus.SS_N = 1'b1;
    bus.MOSI = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
    if (!rst_hit && n > 0) begin
      keep = (n > MAXLEN) ? MAXLEN : n;
      exp_q.push_back({8'((bits >> (n - keep)) & ((16'd1 << keep) - 16'd1)),
                       4'(keep), (n > MAXLEN)});
    end
  endtask

  task automatic check_rx();
    rx_t g;
    rx_t e;
    repeat (12) @(posedge clk);
    #1;
    check("rx_count", got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check("rx_data", {24'd0, g.d}, {24'd0, e.d});
      check("rx_nbits", {28'd0, g.n}, {28'd0, e.n});
      check("rx_overrun", {31'd0, g.o}, {31'd0, e.o});
    end
    got_q.delete();
    exp_q.delete();
    check("tx_underrun_count", und_cnt, exp_und);
    check("overrun_without_valid", ovr_alone, 0);
    check("miso_idle", {31'd0, bus.MISO}, 32'd0);
    check("tx_ready_model", {31'd0, bus.tx_ready}, {31'd0, !model_full});
  endtask

  initial begin
    sreset       = 1'b1;
    bus.SS_N     = 1'b1;
    bus.SCLK     = 1'b0;
    bus.MOSI     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    model_full   = 1'b0;
    model_word   = '0;
    repeat (4) @(posedge clk);
    #1;
    sreset = 1'b0;

    check("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
    check("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
    check("rst_rx_nbits", {28'd0, bus.rx_nbits}, 32'd0);
    check("rst_tx_underrun", {31'd0, bus.tx_underrun}, 32'd0);
    check("rst_rx_overrun", {31'd0, bus.rx_overrun}, 32'd0);
    check("rst_miso", {31'd0, bus.MISO}, 32'd0);
    repeat (10) @(posedge clk);
    #1;

    // Full 8-bit frame with a preloaded word.
    load_tx(8'h5C);
    check("tx_ready_full", {31'd0, bus.tx_ready}, 32'd0);
    run_frame(8, 16'h00AB, H, -1, 1'b0, 8'h00);
    check("tx_ready_after_fall", {31'd0, bus.tx_ready}, 32'd1);
    check_rx();

    // Short frame sends only the top bits.
    load_tx(8'hA0);
    run_frame(3, 16'h0005, H, -1, 1'b0, 8'h00);
    check_rx();

    // Underrun, word offered in the SS_N-fall cycle is kept for next frame.
    run_frame(8, 16'h00FF, H, -1, 1'b1, 8'h3C);
    run_frame(8, 16'(($urandom) & 32'hFF), H, -1, 1'b0, 8'h00);
    check_rx();

    // Over-long frame.
    load_tx(8'($urandom));
    run_frame(10, 16'h02AB, H, -1, 1'b0, 8'h00);
    check_rx();

    // Select without clocks: no rx word, buffer still consumed.
    load_tx(8'h77);
    run_frame(0, 16'h0000, H, -1, 1'b0, 8'h00);
    check_rx();

    // Reset in the middle of a frame, then a clean frame.
    run_frame(8, 16'h00C3, H, 4, 1'b1, 8'h66);
    run_frame(8, 16'h0081, H, -1, 1'b0, 8'h00);
    check_rx();

    // Back-to-back frames, SS_N high for SYNC+2 clk.
    load_tx(8'h12);
    run_frame(8, 16'h0034, SYNC + 1, -1, 1'b0, 8'h00);
    run_frame(8, 16'h00E7, H, -1, 1'b0, 8'h00);
    check_rx();

    // Randomized frames.
    for (int r = 0; r < 12; r++) begin
      if ($urandom_range(0, 1) == 1) load_tx(8'($urandom));
      if ($urandom_range(0, 3) == 0) load_tx(8'($urandom));
      run_frame(int'($urandom_range(0, 10)), 16'($urandom), H, -1, 1'b0, 8'h00);
    end
    check_rx();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
